// File: rtl/tcam_axis_pkg.sv
// Constants and state encodings shared by the TCAM AXI-Stream wrapper and its command packer.
package tcam_axis_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitRsp,
        StResp
    } tcam_state_e;

    localparam int unsigned CTRL_OPCODE_BIT = 0;
    localparam int unsigned CTRL_CLR_BIT    = 1;
    localparam int unsigned HDR_ADDR_LSB    = 16;
    localparam int unsigned BEATS_PER_FRAME = 4;
    localparam logic [31:0] MISS_PATTERN    = 32'hDEADBEEF;

    // Header beat: address in the top half, control bits at the bottom.
    function automatic logic [31:0] make_header(input logic [15:0] addr, input logic clr,
                                                input logic opcode);
        logic [31:0] hdr;
        hdr                   = '0;
        hdr[HDR_ADDR_LSB+:16] = addr;
        hdr[CTRL_CLR_BIT]     = clr;
        hdr[CTRL_OPCODE_BIT]  = opcode;
        return hdr;
    endfunction

endpackage

// File: rtl/tcam_cmd_packer_if.sv
// One AXI-Stream link; master drives data, slave drives TREADY.
interface tcam_cmd_packer_if #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) ();

    logic                              TVALID;
    logic [C_AXIS_TDATA_WIDTH-1:0]     TDATA;
    logic [(C_AXIS_TDATA_WIDTH/8)-1:0] TSTRB;
    logic                              TLAST;
    logic                              TREADY;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);

endinterface

// File: rtl/tcam_cmd_packer.sv
// Serialises one parallel TCAM command into a header/word/mask/data frame, then waits for the
// single response beat (or a timeout) and presents the decoded result.
module tcam_cmd_packer
    import tcam_axis_pkg::*;
#(
    parameter int unsigned WORD_WIDTH         = 32,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_opcode,
    input  logic                          cmd_clr,
    input  logic [15:0]                   cmd_addr,
    input  logic [WORD_WIDTH-1:0]         cmd_word,
    input  logic [WORD_WIDTH-1:0]         cmd_mask,
    input  logic [DATA_WIDTH-1:0]         cmd_data,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_hit,
    output logic [C_AXIS_TDATA_WIDTH-1:0] rsp_data,
    output logic                          rsp_timeout,
    output logic                          rsp_opcode,
    output logic                          stray_drop,

    tcam_cmd_packer_if.master             m_axis,
    tcam_cmd_packer_if.slave              s_axis
);

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LastBeat = 2'(BEATS_PER_FRAME - 1);

    if (WORD_WIDTH != C_AXIS_TDATA_WIDTH) begin : g_bad_word_width
        $error("WORD_WIDTH must equal C_AXIS_TDATA_WIDTH");
    end
    if (DATA_WIDTH != C_AXIS_TDATA_WIDTH) begin : g_bad_data_width
        $error("DATA_WIDTH must equal C_AXIS_TDATA_WIDTH");
    end
    if (C_AXIS_TDATA_WIDTH < 32) begin : g_bad_bus_width
        $error("C_AXIS_TDATA_WIDTH must hold the 32-bit header");
    end
    if (TIMEOUT_CYCLES < 8) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 8");
    end

    tcam_state_e                   state_q, state_d;
    logic [1:0]                    beat_cnt_q, beat_cnt_d;
    logic [TimerWidth-1:0]         timer_q, timer_d;
    logic                          opcode_q, opcode_d;
    logic                          clr_q, clr_d;
    logic [15:0]                   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]         word_q, word_d;
    logic [WORD_WIDTH-1:0]         mask_q, mask_d;
    logic [DATA_WIDTH-1:0]         data_q, data_d;
    logic                          hit_q, hit_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                          timeout_q, timeout_d;
    logic                          stray_q, stray_d;

    logic unused_tstrb;
    assign unused_tstrb = ^s_axis.TSTRB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            timer_q    <= '0;
            opcode_q   <= 1'b0;
            clr_q      <= 1'b0;
            addr_q     <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            rdata_q    <= '0;
            timeout_q  <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            timer_q    <= timer_d;
            opcode_q   <= opcode_d;
            clr_q      <= clr_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            hit_q      <= hit_d;
            rdata_q    <= rdata_d;
            timeout_q  <= timeout_d;
            stray_q    <= stray_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        timer_d    = timer_q;
        opcode_d   = opcode_q;
        clr_d      = clr_q;
        addr_d     = addr_q;
        word_d     = word_q;
        mask_d     = mask_q;
        data_d     = data_q;
        hit_d      = hit_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        // Beats seen in IDLE belong to no command (e.g. a response after a timeout).
        stray_d    = (state_q == StIdle) && s_axis.TVALID;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    opcode_d   = cmd_opcode;
                    clr_d      = cmd_clr;
                    addr_d     = cmd_addr;
                    word_d     = cmd_word;
                    mask_d     = cmd_mask;
                    data_d     = cmd_data;
                    beat_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (m_axis.TREADY) begin
                    if (beat_cnt_q == LastBeat) begin
                        timer_d = '0;
                        state_d = StWaitRsp;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            StWaitRsp: begin
                // A beat in the expiry cycle takes priority over the timeout.
                if (s_axis.TVALID) begin
                    timeout_d = 1'b0;
                    if (opcode_q) begin
                        hit_d   = s_axis.TLAST;
                        rdata_d = s_axis.TLAST ? s_axis.TDATA : '0;
                    end else begin
                        hit_d   = 1'b1;
                        rdata_d = '0;
                    end
                    state_d = StResp;
                end else if (timer_q == TimerLast) begin
                    timeout_d = 1'b1;
                    hit_d     = 1'b0;
                    rdata_d   = '0;
                    state_d   = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == StIdle);
        s_axis.TREADY = (state_q == StIdle) || (state_q == StWaitRsp);
        m_axis.TVALID = (state_q == StSend);
        m_axis.TLAST  = (state_q == StSend) && (beat_cnt_q == LastBeat);
        m_axis.TSTRB  = '1;
        m_axis.TDATA  = '0;
        if (state_q == StSend) begin
            unique case (beat_cnt_q)
                2'd0:    m_axis.TDATA = C_AXIS_TDATA_WIDTH'(make_header(addr_q, clr_q, opcode_q));
                2'd1:    m_axis.TDATA = C_AXIS_TDATA_WIDTH'(word_q);
                2'd2:    m_axis.TDATA = C_AXIS_TDATA_WIDTH'(mask_q);
                default: m_axis.TDATA = C_AXIS_TDATA_WIDTH'(data_q);
            endcase
        end
        rsp_valid   = (state_q == StResp);
        rsp_hit     = hit_q;
        rsp_data    = rdata_q;
        rsp_timeout = timeout_q;
        rsp_opcode  = opcode_q;
        stray_drop  = stray_q;
    end

endmodule

// File: tb/tb_tcam_cmd_packer.sv
// Self-checking bench: table-driven commands with beat and response scoreboards, plus stall,
// timeout/stray and mid-frame reset sequences.
module tb_tcam_cmd_packer;

    localparam int unsigned TO = 64;

    typedef struct {
        logic        opcode;
        logic        clr;
        logic [15:0] addr;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] rsp_tdata;
        logic        rsp_tlast;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        hit;
        logic [31:0] data;
        logic        timeout;
        logic        opcode;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_opcode = 1'b0;
    logic        cmd_clr = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_word = '0;
    logic [31:0] cmd_mask = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        rsp_opcode;
    logic        stray_drop;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];

    tcam_cmd_packer_if #(.C_AXIS_TDATA_WIDTH(32)) m_axis_if ();
    tcam_cmd_packer_if #(.C_AXIS_TDATA_WIDTH(32)) s_axis_if ();

    tcam_cmd_packer #(
        .WORD_WIDTH(32), .DATA_WIDTH(32), .C_AXIS_TDATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_clr(cmd_clr), .cmd_addr(cmd_addr), .cmd_word(cmd_word), .cmd_mask(cmd_mask),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .rsp_opcode(rsp_opcode), .stray_drop(stray_drop),
        .m_axis(m_axis_if), .s_axis(s_axis_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Beat monitor: pops the expected frame on each handshake, checks hold during stalls.
    initial begin
        logic        stalled;
        logic [31:0] held_data;
        logic        held_last;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_tvalid", 32'(m_axis_if.TVALID), 32'd1);
                    check("stall_tdata", m_axis_if.TDATA, held_data);
                    check("stall_tlast", 32'(m_axis_if.TLAST), 32'(held_last));
                end
                if (m_axis_if.TVALID && m_axis_if.TREADY) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", m_axis_if.TDATA, 32'hxxxx_xxxx);
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        check("beat_tdata", m_axis_if.TDATA, b.data);
                        check("beat_tlast", 32'(m_axis_if.TLAST), 32'(b.last));
                    end
                end
                stalled = m_axis_if.TVALID && !m_axis_if.TREADY;
                if (stalled) stall_cnt++;
                held_data = m_axis_if.TDATA;
                held_last = m_axis_if.TLAST;
            end
        end
    end

    task automatic push_frame(input vec_t v);
        beat_t b;
        b.data = {v.addr, 14'b0, v.clr, v.opcode}; b.last = 1'b0; beat_q.push_back(b);
        b.data = v.word;                           b.last = 1'b0; beat_q.push_back(b);
        b.data = v.mask;                           b.last = 1'b0; beat_q.push_back(b);
        b.data = v.data;                           b.last = 1'b1; beat_q.push_back(b);
    endtask

    task automatic send_cmd(input vec_t v, input bit stall);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = v.opcode; cmd_clr = v.clr; cmd_addr = v.addr;
        cmd_word = v.word; cmd_mask = v.mask; cmd_data = v.data;
        push_frame(v);
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_axis_if.TREADY = stall ? pat[i % 4] : 1'b1;
            @(negedge clk); #1;
            if (beat_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("frame_done", 32'(beat_q.size()), 32'd0);
    endtask

    task automatic get_rsp(input bit drive, input logic [31:0] tdata, input logic tlast,
                           output int lat);
        rsp_t e;
        @(posedge clk); #1;
        if (drive) begin
            s_axis_if.TVALID = 1'b1; s_axis_if.TDATA = tdata; s_axis_if.TLAST = tlast;
            @(negedge clk);
            check("s_tready_wait", 32'(s_axis_if.TREADY), 32'd1);
            @(posedge clk); #1;
            s_axis_if.TVALID = 1'b0;
        end
        lat = 0;
        for (int i = 0; i < int'(TO) + 20; i++) begin
            @(negedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        if (rsp_q.size() == 0) begin
            check("rsp_queue", 32'd0, 32'd1);
        end else begin
            e = rsp_q.pop_front();
            for (int k = 0; k < 2; k++) begin
                check("rsp_hit", 32'(rsp_hit), 32'(e.hit));
                check("rsp_data", rsp_data, e.data);
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
                check("rsp_opcode", 32'(rsp_opcode), 32'(e.opcode));
                check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
                check("s_tready_resp", 32'(s_axis_if.TREADY), 32'd0);
                if (k == 0) begin
                    @(negedge clk); #1;
                    check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                end
            end
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("rsp_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run(input vec_t v, input bit stall);
        rsp_t e;
        int   lat;
        e.hit = v.exp_hit; e.data = v.exp_data; e.timeout = 1'b0; e.opcode = v.opcode;
        rsp_q.push_back(e);
        send_cmd(v, stall);
        get_rsp(1'b1, v.rsp_tdata, v.rsp_tlast, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v;
        rsp_t e;
        int   lat;
        int   strays;

        //            op    clr   addr      word          mask          data
        //            rsp_tdata     tlast exp_hit exp_data
        vecs[0] = '{1'b0, 1'b0, 16'h0003, 32'h0000_00AA, 32'h0, 32'h1234_5678,
                    32'h5555_5555, 1'b1, 1'b1, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 32'h0000_00AA, 32'h0, 32'h0,
                    32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 32'h0000_00AA, 32'h0, 32'h0,
                    32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 32'hA5A5_0F0F, 32'hFF00_FF00, 32'h0BAD_F00D,
                    32'h7777_7777, 1'b0, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 16'h1234, 32'hCAFE_0001, 32'h0000_FFFF, 32'h0,
                    32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D};

        m_axis_if.TREADY = 1'b1;
        s_axis_if.TVALID = 1'b0; s_axis_if.TDATA = '0; s_axis_if.TSTRB = 4'hF;
        s_axis_if.TLAST = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tstrb", 32'(m_axis_if.TSTRB), 32'hF);
        check("rst_tvalid", 32'(m_axis_if.TVALID), 32'd0);
        check("rst_tlast", 32'(m_axis_if.TLAST), 32'd0);
        check("rst_tdata", m_axis_if.TDATA, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_hit", 32'(rsp_hit), 32'd0);
        check("rst_stray", 32'(stray_drop), 32'd0);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run(vecs[i], 1'b0);

        // Ready pattern 1-0-0-1 repeated: beats on cycles 0,3,4,7, four stall cycles.
        stall_cnt = 0;
        run(vecs[0], 1'b1);
        check("stall_cycles", 32'(stall_cnt), 32'd4);

        // Timeout, then the late beat must be dropped as a stray.
        v = vecs[1];
        e.hit = 1'b0; e.data = 32'h0; e.timeout = 1'b1; e.opcode = 1'b1;
        rsp_q.push_back(e);
        send_cmd(v, 1'b0);
        get_rsp(1'b0, 32'h0, 1'b0, lat);
        check("timeout_latency", 32'(lat), 32'(TO + 1));
        @(posedge clk); #1;
        s_axis_if.TVALID = 1'b1; s_axis_if.TDATA = 32'h1234_5678; s_axis_if.TLAST = 1'b1;
        strays = 0;
        @(negedge clk); strays += int'(stray_drop);
        @(posedge clk); #1; s_axis_if.TVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); strays += int'(stray_drop);
        end
        check("stray_pulses", 32'(strays), 32'd1);
        check("stray_no_rsp", 32'(rsp_valid), 32'd0);
        v = vecs[4];
        v.rsp_tdata = 32'h0BAD_CAFE; v.exp_data = 32'h0BAD_CAFE;
        run(v, 1'b0);

        // Reset while the second beat is on the bus.
        v = vecs[3];
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = v.opcode; cmd_clr = v.clr; cmd_addr = v.addr;
        cmd_word = v.word; cmd_mask = v.mask; cmd_data = v.data;
        push_frame(v);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (beat_q.size() == 3) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("mid_tvalid_pre", 32'(m_axis_if.TVALID), 32'd1);
        check("mid_tdata_pre", m_axis_if.TDATA, v.word);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_if.TVALID), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        beat_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rel_tvalid", 32'(m_axis_if.TVALID), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check("mid_no_completion", 32'(rsp_valid), 32'd0);

        check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
